// File: rtl/flt2int_pkg.sv
// Shared types and constants for the half-precision to int16 converter.
// The shift reference folds the exponent bias and the 10 fraction bits together.
package flt2int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    LOAD,
    CALC,
    STORE,
    FINISH
  } state_t;

  localparam int EXP_BIAS  = 15;
  localparam int SHIFT_REF = EXP_BIAS + 10;
  localparam int MEM_DEPTH = 256;
  localparam int IN_ADDR   = 4;
  localparam int OUT_ADDR  = 6;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Distance of the exponent from the integer point; 11 or more clears an
  // 11-bit mantissa, so the count is capped there to bound the CALC time.
  function automatic logic [3:0] shift_count(input logic [4:0] e);
    logic [4:0] d;
    if (e >= 5'(SHIFT_REF)) d = e - 5'(SHIFT_REF);
    else                    d = 5'(SHIFT_REF) - e;
    if (d > 5'd11) d = 5'd11;
    return d[3:0];
  endfunction

endpackage

// File: rtl/flt2int_converter_if.sv
// Start/Done handshake between the control logic and the converter.
interface flt2int_converter_if;
  logic Start;
  logic Done;

  modport master (output Start, input Done);
  modport slave  (input Start, output Done);
endinterface

// File: rtl/flt2int_converter_dat_mem.sv
// Byte-wide data memory: synchronous 16-bit little-endian write, combinational read.
// Contents are deliberately not reset so preloaded operands survive a reset.
module dat_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [7:0] core [0:DEPTH-1];

  logic [AW-1:0] rd_addr_hi;
  logic [AW-1:0] wr_addr_hi;

  assign rd_addr_hi = AW'(rd_addr + 1'b1);
  assign wr_addr_hi = AW'(wr_addr + 1'b1);
  assign rd_data    = {core[rd_addr_hi], core[rd_addr]};

  always_ff @(posedge clk) begin
    if (we) begin
      core[wr_addr]    <= wr_data[7:0];
      core[wr_addr_hi] <= wr_data[15:8];
    end
  end

endmodule

// File: rtl/flt2int_converter.sv
// Half-precision float to signed 16-bit integer, truncating toward zero.
// Operand and result live in the internal memory DM1; Start/Done frame each conversion.
//
// state    | meaning
// IDLE     | waiting for Start, Done holds the previous completion
// WAIT_LOW | Start seen, waiting for it to drop
// LOAD     | read float, classify, seed shift count
// CALC     | one mantissa shift per cycle, then apply sign/saturation
// STORE    | write result bytes
// FINISH   | raise Done
module flt2int_converter
  import flt2int_pkg::*;
#(
  parameter int MEM_DEPTH = flt2int_pkg::MEM_DEPTH,
  parameter int IN_ADDR   = flt2int_pkg::IN_ADDR,
  parameter int OUT_ADDR  = flt2int_pkg::OUT_ADDR
) (
  input  logic          Clk,
  input  logic          Reset,
  flt2int_converter_if.slave hs
);

  state_t      state;
  logic        done_r;
  logic        sign;
  logic        sat;
  logic        zero;
  logic        shl;
  logic [3:0]  cnt;
  logic [15:0] mag;
  logic [15:0] res;
  logic [15:0] rd_data;
  logic [4:0]  exp_f;
  logic        we;

  assign exp_f   = rd_data[14:10];
  assign we      = (state == STORE);
  assign hs.Done = done_r;

  dat_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (8)
  ) DM1 (
    .clk     (Clk),
    .we      (we),
    .wr_addr (8'(OUT_ADDR)),
    .wr_data (res),
    .rd_addr (8'(IN_ADDR)),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      done_r <= 1'b0;
      sign   <= 1'b0;
      sat    <= 1'b0;
      zero   <= 1'b0;
      shl    <= 1'b0;
      cnt    <= '0;
      mag    <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs.Start) begin
            done_r <= 1'b0;
            state  <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!hs.Start) state <= LOAD;
        end
        LOAD: begin
          sign <= rd_data[15];
          mag  <= {5'b0, 1'b1, rd_data[9:0]};
          zero <= (exp_f == 5'd0);
          sat  <= (exp_f >= 5'd30);
          shl  <= (exp_f >= 5'(SHIFT_REF));
          // Special cases skip the shifter entirely.
          if (exp_f == 5'd0 || exp_f >= 5'd30) cnt <= '0;
          else                                 cnt <= shift_count(exp_f);
          state <= CALC;
        end
        CALC: begin
          if (cnt != 4'd0) begin
            mag <= shl ? (mag << 1) : (mag >> 1);
            cnt <= cnt - 4'd1;
          end else begin
            if (zero)     res <= '0;
            else if (sat) res <= sign ? SAT_NEG : SAT_POS;
            else          res <= sign ? (~mag + 16'd1) : mag;
            state <= STORE;
          end
        end
        STORE: begin
          state <= FINISH;
        end
        FINISH: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_converter.sv
// Directed-vector bench: stimulus pushes expected results, a monitor checks memory on each Done rise.
module tb_flt2int_converter;
  import flt2int_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_res;
  logic        done_q = 1'b0;

  flt2int_converter_if hs();

  flt2int_converter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .hs    (hs)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [15:0] out_word();
    return {dut.DM1.core[OUT_ADDR+1], dut.DM1.core[OUT_ADDR]};
  endfunction

  // Monitor: compare the stored result whenever Done rises.
  always @(negedge Clk) begin
    if (hs.Done === 1'b1 && done_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h required=none", out_word());
      end else begin
        check("result", out_word(), exp_q.pop_front());
      end
    end
    done_q = hs.Done;
  end

  task automatic convert(input logic [15:0] f, input logic [15:0] r);
    int n;
    @(negedge Clk);
    dut.DM1.core[IN_ADDR]   = f[7:0];
    dut.DM1.core[IN_ADDR+1] = f[15:8];
    exp_q.push_back(r);
    last_res = r;
    hs.Start = 1'b1;
    @(negedge Clk);
    hs.Start = 1'b0;
    check("done_fall", 16'(hs.Done), 16'd0);
    n = 0;
    while (hs.Done !== 1'b1 && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("done_rise", 16'(hs.Done), 16'd1);
    repeat (3) @(negedge Clk);
    check("done_hold", 16'(hs.Done), 16'd1);
  endtask

  logic [31:0] vecs[$] = '{
    32'h3C00_0001, 32'h4000_0002, 32'h4200_0003, 32'h4040_0002,
    32'h4B00_000E, 32'h4B80_000F, 32'h6300_0380, 32'h6700_0700,
    32'h7780_7800, 32'hBC00_FFFF, 32'hBD00_FFFF, 32'hC200_FFFD,
    32'hCB80_FFF1, 32'h0000_0000, 32'h8000_0000, 32'h7B80_7FFF,
    32'hFB80_8000, 32'h7C00_7FFF, 32'h0200_0000, 32'h1400_0000,
    32'h3800_0000, 32'hB800_0000, 32'h77FF_7FF0
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    hs.Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_done", 16'(hs.Done), 16'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("idle_done", 16'(hs.Done), 16'd0);

    foreach (vecs[i]) convert(vecs[i][31:16], vecs[i][15:0]);

    // Abort a conversion while it is shifting; the previous result must survive.
    @(negedge Clk);
    dut.DM1.core[IN_ADDR]   = 8'h00;
    dut.DM1.core[IN_ADDR+1] = 8'h3C;
    hs.Start = 1'b1;
    @(negedge Clk);
    hs.Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("pre_rst_state", 16'(dut.state), 16'(CALC));
    Reset = 1'b1;
    #1;
    check("rst_done", 16'(hs.Done), 16'd0);
    check("rst_state", 16'(dut.state), 16'(IDLE));
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    check("rst_no_write", out_word(), last_res);
    check("rst_done_low", 16'(hs.Done), 16'd0);

    convert(16'hC200, 16'hFFFD);
    convert(16'h4B80, 16'h000F);

    repeat (5) @(negedge Clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flt2int_converter.md
Name: flt2int_converter

Overview:
- Converts an IEEE-754 half-precision value into a signed 16-bit two's-complement integer.
- Truncates toward zero; no rounding.
- The block owns an internal byte-wide data memory. The float is pre-loaded at bytes 5:4; the integer result is written to bytes 7:6.
- Start/Done handshake with the surrounding test or control logic.

Parameters:
- MEM_DEPTH, 256, number of bytes in the data memory (8-bit address).
- IN_ADDR, 4, low-byte address of the input float; high byte is at IN_ADDR+1.
- OUT_ADDR, 6, low-byte address of the output integer; high byte is at OUT_ADDR+1.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; high for about one clock after the input bytes are loaded.
- Done  output  1  result valid in memory; held high until the next Start.

Behaviour:
- Memory
  - Instance DM1, byte array named core[0:MEM_DEPTH-1].
  - Externally writable and readable by hierarchical access.
  - Not cleared by Reset.
- Reset (async): state = IDLE, Done = 0, internal registers cleared, no memory write.
- State machine:
  - IDLE: Start=1 -> WAIT_LOW and Done <= 0.
  - WAIT_LOW: stay while Start=1; Start=0 -> LOAD.
  - LOAD: read core[IN_ADDR+1] as f[15:8] and core[IN_ADDR] as f[7:0] -> CALC.
  - CALC: compute the result (one or more shift cycles) -> STORE.
  - STORE: write r[15:8] to core[OUT_ADDR+1] and r[7:0] to core[OUT_ADDR] -> FINISH.
  - FINISH: Done <= 1 -> IDLE.
- Latency: Done rises at most 40 cycles after Start falls. The memory write completes strictly before Done rises.
- Done stays high in IDLE and falls on the first cycle Start is sampled high.
- Start asserted mid-conversion is ignored. Reset mid-conversion aborts with no write.
- Arithmetic (s = f[15], e = f[14:10], m = {1, f[9:0]}, 11 bits):
  - e == 0 (zero or denormal): r = 0. Covers both +0 and -0 (0x8000 -> 0x0000).
  - e >= 30 (unbiased exponent > 14, including inf/NaN): r = 0x7FFF if s=0, 0x8000 if s=1.
  - 25 <= e <= 29: mag = m << (e-25); maximum 32752, fits in 15 bits.
  - 1 <= e <= 24: mag = m >> (25-e). Shifts of 11 or more give 0. Fractional bits are discarded.
  - Final result: r = s ? -mag : mag, 16-bit two's complement. -32768 arises only from saturation.

Decomposition:
- Shared package flt2int_pkg holds:
  - state enum {IDLE, WAIT_LOW, LOAD, CALC, STORE, FINISH};
  - constants EXP_BIAS=15, SAT_POS=16'h7FFF, SAT_NEG=16'h8000, IN_ADDR, OUT_ADDR.
- One sub-module, dat_mem: synchronous-write, combinational-read 8-bit memory. Instantiated as DM1 with array core.
- FSM and converter datapath live in the top level.

Test Plan:
- Unit and small values:
  - 0x3C00 -> 0x0001; 0x4000 -> 0x0002; 0x4200 -> 0x0003.
  - 0x4040 (2.125) -> 0x0002, truncated.
- Mid and large magnitudes:
  - 0x4B00 -> 14 (0x000E); 0x4B80 -> 15 (0x000F).
  - 0x6300 -> 896; 0x6700 -> 1792; 0x7780 -> 30720 (0x7800).
- Negatives:
  - 0xBC00 -> 0xFFFF; 0xBD00 (-1.25) -> 0xFFFF; 0xC200 -> 0xFFFD; 0xCB80 -> 0xFFF1.
- Zero and saturation:
  - 0x0000 -> 0x0000; 0x8000 -> 0x0000.
  - 0x7B80 -> 0x7FFF; 0xFB80 -> 0x8000; 0x7C00 -> 0x7FFF.
- Handshake:
  - Done=0 after reset.
  - Start pulse -> Done falls within 1 cycle, rises within 40 cycles, stays high; bytes 7:6 are correct when Done rises.
  - A second Start lowers Done again.
- Reset mid-CALC:
  - Done=0, state IDLE, bytes 7:6 unchanged.
  - The next Start converts normally.
